// File: rtl/crossbar_input_conditioner.sv
// Conditions the raw slide switches and push button for the 2x2 crossbar: two-flop sync,
// whole-group debounce, and a press FSM toggling control. Macro XBAR_AUTO_SWAP_EN adds periodic auto swap.
module crossbar_input_conditioner #(
    parameter int WIDTH       = 4,
    parameter int DB_CYCLES   = 65536,
    parameter int AUTO_PERIOD = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw1_raw,
    input  logic [WIDTH-1:0] sw2_raw,
    input  logic             btn_raw,
    output logic [WIDTH-1:0] sw1_out,
    output logic [WIDTH-1:0] sw2_out,
    output logic             control,
    output logic             toggle_pulse
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_e;

    // Index 0 is switch group 1, index 1 is switch group 2.
    logic [1:0][WIDTH-1:0] raw_s;
    logic [1:0][WIDTH-1:0] meta_q, sync_q, cand_q, cand_d, out_q, out_d;
    logic [1:0][CW-1:0]    cnt_q, cnt_d;

    logic       btn_meta_q, btn_sync_q;
    btn_state_e state_q;
    logic [CW-1:0] btn_cnt_q;
    logic       control_q, pulse_q;
    logic       btn_fire_s, auto_wrap_s, swap_s;

    assign raw_s = {sw2_raw, sw1_raw};

    // Next-state for the per-group candidate, stability counter and debounced output
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        for (int g = 0; g < 2; g++) begin
            if (sync_q[g] != cand_q[g]) begin
                cand_d[g] = sync_q[g];
                cnt_d[g]  = '0;
            end else if (cnt_q[g] != CNT_MAX) begin
                cnt_d[g] = cnt_q[g] + CNT_ONE;
            end else begin
                out_d[g] = cand_q[g];
            end
        end
    end

    // Synchroniser flops and switch debounce registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            meta_q     <= raw_s;
            sync_q     <= meta_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign btn_fire_s = (state_q == PRESS_CHK) && btn_sync_q && (btn_cnt_q == CNT_MAX);

`ifdef XBAR_AUTO_SWAP_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);
    localparam logic [AW-1:0] AUTO_ONE = AW'(1'b1);

    logic [AW-1:0] auto_cnt_q;

    assign auto_wrap_s = (auto_cnt_q == AUTO_MAX);

    // Free-running swap period counter; a button toggle restarts the period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else if (btn_fire_s || auto_wrap_s) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_q + AUTO_ONE;
        end
    end
`else
    assign auto_wrap_s = 1'b0;
`endif

    // Coincident button and auto events collapse into a single inversion.
    assign swap_s = btn_fire_s | auto_wrap_s;

    // Button press/release FSM with registered control and strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_cnt_q <= '0;
            control_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= swap_s;
            if (swap_s) begin
                control_q <= ~control_q;
            end
            case (state_q)
                IDLE: begin
                    if (btn_sync_q) begin
                        state_q   <= PRESS_CHK;
                        btn_cnt_q <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_sync_q) begin
                        state_q <= IDLE;
                    end else if (btn_cnt_q == CNT_MAX) begin
                        state_q <= HELD;
                    end else begin
                        btn_cnt_q <= btn_cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_sync_q) begin
                        state_q   <= REL_CHK;
                        btn_cnt_q <= '0;
                    end
                end
                REL_CHK: begin
                    if (btn_sync_q) begin
                        state_q <= HELD;
                    end else if (btn_cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        btn_cnt_q <= btn_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sw1_out      = out_q[0];
    assign sw2_out      = out_q[1];
    assign control      = control_q;
    assign toggle_pulse = pulse_q;

endmodule
